// File: rtl/simon_share_arbiter_if.sv
// Bundle between two requesters, the share arbiter and one SIMON engine.
// slave = arbiter view, master = environment (requesters + engine) view.
interface simon_share_arbiter_if #(
  parameter int N = 16,
  parameter int M = 4
);
  logic                  req0;
  logic                  req1;
  logic [2*N-1:0]        plain0;
  logic [2*N-1:0]        plain1;
  logic [M-1:0][N-1:0]   key0;
  logic [M-1:0][N-1:0]   key1;
  logic                  done0;
  logic                  done1;
  logic [2*N-1:0]        cipher;
  logic                  eng_nR;
  logic                  eng_newData;
  logic                  eng_readData;
  logic [2*N-1:0]        eng_plain;
  logic [M-1:0][N-1:0]   eng_key;
  logic                  eng_doneData;
  logic [2*N-1:0]        eng_cipher;

  modport slave (
    input  req0, req1, plain0, plain1, key0, key1, eng_doneData, eng_cipher,
    output done0, done1, cipher, eng_nR, eng_newData, eng_readData, eng_plain, eng_key
  );

  modport master (
    output req0, req1, plain0, plain1, key0, key1, eng_doneData, eng_cipher,
    input  done0, done1, cipher, eng_nR, eng_newData, eng_readData, eng_plain, eng_key
  );
endinterface

// File: rtl/simon_share_arbiter.sv
// Round-robin sharing of one SIMON engine between two requesters.
// Optional macro SIMON_ARB_KEYCACHE_EN: skip the engine reset when the granted key is unchanged.
module simon_share_arbiter #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int HB = 2
) (
  input  logic                  clk,
  input  logic                  R,
  simon_share_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, KRST, LOAD, BUSY, READ, RESP} state_t;

  // Holdoff may never outlast the engine itself, or a genuine result would be skipped.
  localparam int HOLD = (HB < T + 3) ? HB : T + 2;
  localparam int CW   = $clog2(HOLD + 2);

  state_t                state;
  state_t                state_d;
  logic [CW-1:0]         hold_cnt;
  logic                  grant;
  logic                  last;
  logic                  key_valid;
  logic                  sel;
  logic                  any_req;
  logic                  need_krst;
  logic                  eng_nr_r;
  logic [2*N-1:0]        cipher_r;
  logic [M-1:0][N-1:0]   key_g;

  assign any_req = bus.req0 || bus.req1;
  assign sel     = (bus.req0 && bus.req1) ? ~last : bus.req1;
  assign key_g   = grant ? bus.key1 : bus.key0;

`ifdef SIMON_ARB_KEYCACHE_EN
  logic [M-1:0][N-1:0]   key_last;
  logic [M-1:0][N-1:0]   sel_key;

  assign sel_key   = sel ? bus.key1 : bus.key0;
  assign need_krst = key_valid && (sel_key != key_last);
`else
  assign need_krst = key_valid;
`endif

  assign bus.eng_plain = grant ? bus.plain1 : bus.plain0;
  assign bus.eng_key   = key_g;
  assign bus.eng_nR    = eng_nr_r;
  assign bus.cipher    = cipher_r;

  always_ff @(posedge clk or posedge R) begin
    if (R) state <= IDLE;
    else   state <= state_d;
  end

  always_comb begin
    state_d          = state;
    bus.eng_newData  = 1'b0;
    bus.eng_readData = 1'b0;
    bus.done0        = 1'b0;
    bus.done1        = 1'b0;
    case (state)
      IDLE: if (any_req) state_d = need_krst ? KRST : LOAD;
      KRST: state_d = LOAD;
      LOAD: begin
        bus.eng_newData = 1'b1;
        state_d         = BUSY;
      end
      BUSY: if ((hold_cnt >= CW'(HOLD)) && bus.eng_doneData) state_d = READ;
      READ: begin
        bus.eng_readData = 1'b1;
        state_d          = RESP;
      end
      RESP: begin
        bus.done0 = ~grant;
        bus.done1 = grant;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // eng_nR is registered from the next state so KRST sees exactly one low cycle.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      grant     <= 1'b0;
      last      <= 1'b1;
      key_valid <= 1'b0;
      cipher_r  <= '0;
      eng_nr_r  <= 1'b0;
      hold_cnt  <= '0;
`ifdef SIMON_ARB_KEYCACHE_EN
      key_last  <= '0;
`endif
    end else begin
      eng_nr_r <= (state_d != KRST);
      if (state == IDLE && any_req) grant <= sel;
      if (state == LOAD) begin
        key_valid <= 1'b1;
        hold_cnt  <= '0;
`ifdef SIMON_ARB_KEYCACHE_EN
        key_last  <= key_g;
`endif
      end
      if (state == BUSY && hold_cnt < CW'(HOLD)) hold_cnt <= hold_cnt + CW'(1);
      if (state == READ) cipher_r <= bus.eng_cipher;
      if (state == RESP) last <= grant;
    end
  end

endmodule
